// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
//
// Capture controller for the PDM microphone path. It produces the microphone
// bit clock and a one-cycle sample strobe for the CIC decimator. It holds the
// decimator in reset while idle and throws away the first decimated words while
// the microphone settles. Decimated PCM words are buffered in a small circular
// FIFO. The FIFO drives a threshold interrupt and a sticky overrun flag.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            capture enable (level)
//   clk_div           PDM half-period minus one, in clk cycles
//   settle_count      decimated samples discarded after each start
//   fifo_thresh       level IRQ threshold (0 disables the level IRQ)
//   pdm_clk           microphone bit clock
//   pdm_sample        one-cycle strobe, coincident with the falling toggle
//   filt_rst          synchronous reset to the decimator
//   pcm_in/_valid_in  decimated PCM word and its one-cycle valid
//   rd_en             pop the FIFO head
//   rd_data           FIFO head, 0 when empty
//   level             FIFO occupancy
//   overrun           sticky dropped-sample flag, cleared by clr_overrun
//   irq               level interrupt OR overrun
//   state             IDLE=0, START=1, SETTLE=2, RUN=3
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pdm_capture_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [7:0]    clk_div,
    input  logic [7:0]    settle_count,
    input  logic [AW:0]   fifo_thresh,
    output logic          pdm_clk,
    output logic          pdm_sample,
    output logic          filt_rst,
    input  logic [15:0]   pcm_in,
    input  logic          pcm_valid_in,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic [AW:0]   level,
    output logic          overrun,
    input  logic          clr_overrun,
    output logic          irq,
    output logic [1:0]    state
);

    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    state_e         state_q;
    logic [7:0]     settle_q;
    logic           filt_rst_q;

    logic [7:0]     div_q, div_d;
    logic           pdm_clk_q, pdm_clk_d;

    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic           overrun_q, overrun_d;

    logic           active;
    logic           div_hit;
    logic           push_req;
    logic           pop_req;
    logic           full;
    logic           push_ok;
    logic           drop;

    // Capture state machine. Dropping enable returns to IDLE from any state and
    // takes priority over every other transition. The settle counter counts
    // down on each discarded word. The move to RUN happens on the word that
    // brings the counter to zero, so the next word is already kept. A zero
    // settle count spends a single cycle in SETTLE. filt_rst is registered
    // alongside the state so the decimator sees a glitch-free reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= 8'd0;
            filt_rst_q <= 1'b1;
        end else if (!enable) begin
            state_q    <= IDLE;
            filt_rst_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= START;
                    filt_rst_q <= 1'b1;
                end
                START: begin
                    state_q    <= SETTLE;
                    settle_q   <= settle_count;
                    filt_rst_q <= 1'b0;
                end
                SETTLE: begin
                    filt_rst_q <= 1'b0;
                    if (settle_q == 8'd0) begin
                        state_q <= RUN;
                    end else if (pcm_valid_in) begin
                        settle_q <= settle_q - 8'd1;
                        if (settle_q == 8'd1) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    filt_rst_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    filt_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign active  = (state_q == SETTLE) || (state_q == RUN);
    assign div_hit = (div_q >= clk_div);

    // Bit-clock divider. The counter runs only while capturing. It restarts
    // whenever we are outside SETTLE/RUN or enable is dropping, so pdm_clk is
    // low on the first idle cycle. The >= compare lets a smaller clk_div take
    // effect at the next compare without wrapping through 255.
    always_comb begin
        div_d     = div_q;
        pdm_clk_d = pdm_clk_q;
        if (!enable || !active) begin
            div_d     = 8'd0;
            pdm_clk_d = 1'b0;
        end else if (div_hit) begin
            div_d     = 8'd0;
            pdm_clk_d = ~pdm_clk_q;
        end else begin
            div_d     = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= 8'd0;
            pdm_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    // The strobe marks the cycle whose closing edge drops pdm_clk. That gives
    // exactly one strobe per PDM period. The strobe is 0 in IDLE/START because
    // pdm_clk is held low there.
    assign pdm_sample = active && pdm_clk_q && div_hit;

    assign push_req = pcm_valid_in && (state_q == RUN);
    assign pop_req  = rd_en && (level_q != '0);
    assign full     = (level_q == FULL_LEVEL);
    assign push_ok  = push_req && (!full || pop_req);
    assign drop     = push_req && full && !pop_req;

    // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
    // of two. A push into a full FIFO still succeeds when a pop happens in the
    // same cycle. START discards anything left over from the previous capture.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (state_q == START) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_req) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_req})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Overrun is sticky. A drop in the same cycle as clr_overrun keeps it set,
    // so software can never miss a loss.
    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array. It has no reset because rd_data is masked to 0 whenever
    // the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pcm_in;
        end
    end

    assign rd_data  = (level_q != '0) ? mem_q[rd_ptr_q] : 16'd0;
    assign irq      = overrun_q | ((fifo_thresh != '0) && (level_q >= fifo_thresh));
    assign level    = level_q;
    assign overrun  = overrun_q;
    assign pdm_clk  = pdm_clk_q;
    assign filt_rst = filt_rst_q;
    assign state    = state_q;

endmodule
